// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and decode stall
module muldiv_unit #(
  parameter int                WIDTH    = 32,
  parameter logic [WIDTH-1:0]  HILO_RST = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startE,
  input  logic [2:0]       opE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             flushE,
  input  logic             mfhiD,
  input  logic             mfloD,
  input  logic             muldivD,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stallD,
  output logic             done,
  output logic             divzero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] acc_q, acc_d, mq_q, mq_d, b_q, b_d, a_raw_q, a_raw_d;
  logic             is_div_q, is_div_d, neg_q, neg_d, rem_neg_q, rem_neg_d;
  logic             dz_q, dz_d, divzero_q, divzero_d, done_q, done_d;

  logic             accept, op_signed, sa, sb;
  logic [WIDTH-1:0] a_mag, b_mag, addend;
  logic [WIDTH:0]   sum, shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    accept    = startE & ~flushE & (state_q == S_IDLE);
    op_signed = (opE == 3'd0) || (opE == 3'd2);
    sa        = op_signed & srcaE[WIDTH-1];
    sb        = op_signed & srcbE[WIDTH-1];
    a_mag     = sa ? -srcaE : srcaE;
    b_mag     = sb ? -srcbE : srcbE;

    // Multiply: conditional add then shift the {acc,mq} pair right.
    addend  = mq_q[0] ? b_q : '0;
    sum     = {1'b0, acc_q} + {1'b0, addend};
    // Divide: shift the next dividend bit into the partial remainder and trial-subtract.
    shifted = {acc_q, mq_q[WIDTH-1]};
    ge      = shifted >= {1'b0, b_q};
    diff    = shifted[WIDTH-1:0] - b_q;
    prod    = neg_q ? -{acc_q, mq_q} : {acc_q, mq_q};

    state_d   = state_q;
    count_d   = count_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    b_d       = b_q;
    a_raw_d   = a_raw_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;
    divzero_d = divzero_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (opE)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              divzero_d = 1'b0;
              state_d   = S_RUN;
              count_d   = '0;
              acc_d     = '0;
              mq_d      = a_mag;
              b_d       = b_mag;
              a_raw_d   = srcaE;
              is_div_d  = opE[1];
              neg_d     = sa ^ sb;
              rem_neg_d = sa;
              dz_d      = (srcbE == '0);
            end
            3'd4: begin
              hi_d      = srcaE;
              divzero_d = 1'b0;
            end
            3'd5: begin
              lo_d      = srcaE;
              divzero_d = 1'b0;
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (flushE) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_q) begin
            acc_d = ge ? diff : shifted[WIDTH-1:0];
            mq_d  = {mq_q[WIDTH-2:0], ge};
          end else begin
            acc_d = sum[WIDTH:1];
            mq_d  = {sum[0], mq_q[WIDTH-1:1]};
          end
          count_d = count_q + 1'b1;
          if (count_q == CW'(WIDTH - 1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flushE) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            {hi_d, lo_d} = prod;
          end else if (dz_q) begin
            lo_d      = '1;
            hi_d      = a_raw_q;
            divzero_d = 1'b1;
          end else begin
            lo_d = neg_q ? -mq_q : mq_q;
            hi_d = rem_neg_q ? -acc_q : acc_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      hi_q      <= HILO_RST;
      lo_q      <= HILO_RST;
      acc_q     <= '0;
      mq_q      <= '0;
      b_q       <= '0;
      a_raw_q   <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      divzero_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      b_q       <= b_d;
      a_raw_q   <= a_raw_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
      divzero_q <= divzero_d;
      done_q    <= done_d;
    end
  end

  assign hi      = hi_q;
  assign lo      = lo_q;
  assign busy    = (state_q != S_IDLE);
  assign stallD  = busy & (mfhiD | mfloD | muldivD);
  assign done    = done_q;
  assign divzero = divzero_q;

endmodule
